// File: rtl/io_writeback_arbiter.sv
// Round-robin arbiter funnelling PORTCOUNT writeback sources into one register-file write port
// through a single output register that can drain and refill in the same cycle.
module io_writeback_arbiter #(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned PORTCOUNT    = 4
) (
  input  logic                             clk,
  input  logic                             async_rst_n,
  input  logic                             clk_en,
  input  logic [PORTCOUNT-1:0]             WritebackACK,
  output logic [PORTCOUNT-1:0]             WritebackREQ,
  input  logic [PORTCOUNT*4-1:0]           WritebackDestReg,
  input  logic [PORTCOUNT*DATABITWIDTH-1:0] WritebackDataIn,
  output logic                             RegWriteACK,
  input  logic                             RegWriteREQ,
  output logic [3:0]                       RegWriteDest,
  output logic [DATABITWIDTH-1:0]          RegWriteData,
  output logic [2:0]                       RegWriteSrc
);

  localparam int unsigned PtrW = $clog2(PORTCOUNT);
  localparam logic [PtrW:0] PortCntW = (PtrW+1)'(PORTCOUNT);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(PORTCOUNT - 1);

  logic                    out_valid_q, out_valid_d;
  logic [3:0]              dest_q, dest_d;
  logic [DATABITWIDTH-1:0] data_q, data_d;
  logic [2:0]              src_q, src_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;

  logic [3:0]              dest_arr [PORTCOUNT];
  logic [DATABITWIDTH-1:0] data_arr [PORTCOUNT];

  for (genvar g = 0; g < PORTCOUNT; g++) begin : g_unpack
    assign dest_arr[g] = WritebackDestReg[g*4 +: 4];
    assign data_arr[g] = WritebackDataIn[g*DATABITWIDTH +: DATABITWIDTH];
  end

  logic            grant_found;
  logic [PtrW-1:0] grant_idx;
  logic [PtrW:0]   cand_sum;
  logic [PtrW-1:0] cand;
  logic            reg_free;
  logic            accept;
  logic            drain;

  // Search starts at ptr_q and wraps modulo PORTCOUNT; first asserted ACK wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int unsigned i = 0; i < PORTCOUNT; i++) begin
      cand_sum = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (cand_sum >= PortCntW) begin
        cand_sum = cand_sum - PortCntW;
      end
      cand = cand_sum[PtrW-1:0];
      if (!grant_found && WritebackACK[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign reg_free = !out_valid_q || RegWriteREQ;
  assign accept   = clk_en && reg_free && grant_found;
  assign drain    = clk_en && out_valid_q && RegWriteREQ;

  always_comb begin
    WritebackREQ = '0;
    for (int unsigned i = 0; i < PORTCOUNT; i++) begin
      WritebackREQ[i] = accept && (grant_idx == PtrW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    dest_d      = dest_q;
    data_d      = data_q;
    src_d       = src_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      dest_d      = dest_arr[grant_idx];
      data_d      = data_arr[grant_idx];
      src_d       = 3'(grant_idx);
      ptr_d       = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    end else if (drain) begin
      // Payload is left stale on a plain drain; only the valid flag drops.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      out_valid_q <= 1'b0;
      dest_q      <= '0;
      data_q      <= '0;
      src_q       <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dest_q      <= dest_d;
      data_q      <= data_d;
      src_q       <= src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign RegWriteACK  = out_valid_q;
  assign RegWriteDest = dest_q;
  assign RegWriteData = data_q;
  assign RegWriteSrc  = src_q;

endmodule

// File: tb/tb_io_writeback_arbiter.sv
// Scoreboard bench for io_writeback_arbiter: stimulus pushes expected entries on accept,
// a monitor pops and compares whenever an entry leaves through the register-file port.
module tb_io_writeback_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned PC = 4;

  logic            clk = 1'b0;
  logic            async_rst_n;
  logic            clk_en;
  logic [PC-1:0]   WritebackACK;
  logic [PC-1:0]   WritebackREQ;
  logic [PC*4-1:0] WritebackDestReg;
  logic [PC*DW-1:0] WritebackDataIn;
  logic            RegWriteACK;
  logic            RegWriteREQ;
  logic [3:0]      RegWriteDest;
  logic [DW-1:0]   RegWriteData;
  logic [2:0]      RegWriteSrc;

  io_writeback_arbiter #(.DATABITWIDTH(DW), .PORTCOUNT(PC)) dut (
    .clk             (clk),
    .async_rst_n     (async_rst_n),
    .clk_en          (clk_en),
    .WritebackACK    (WritebackACK),
    .WritebackREQ    (WritebackREQ),
    .WritebackDestReg(WritebackDestReg),
    .WritebackDataIn (WritebackDataIn),
    .RegWriteACK     (RegWriteACK),
    .RegWriteREQ     (RegWriteREQ),
    .RegWriteDest    (RegWriteDest),
    .RegWriteData    (RegWriteData),
    .RegWriteSrc     (RegWriteSrc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    dest;
    logic [DW-1:0] data;
    logic [2:0]    src;
  } entry_t;

  logic [3:0]    dest_tab [PC] = '{4'd1, 4'd7, 4'd5, 4'd14};
  logic [DW-1:0] data_tab [PC] = '{16'h1234, 16'hA5A5, 16'hBEEF, 16'h0F0F};

  entry_t exp_q [$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive ACK at posedge+1, check the combinational grant at negedge, return at posedge+1.
  task automatic step(input logic [PC-1:0] ack, input logic [PC-1:0] exp_req);
    entry_t e;
    WritebackACK = ack;
    @(negedge clk);
    chk("wbreq", 32'(WritebackREQ), 32'(exp_req));
    for (int i = 0; i < PC; i++) begin
      if (exp_req[i]) begin
        e.dest = dest_tab[i];
        e.data = data_tab[i];
        e.src  = 3'(i);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: an entry leaves whenever valid, ready and clk_en coincide at the next edge.
  always @(negedge clk) begin
    entry_t e;
    chk("req_onehot0", 32'($onehot0(WritebackREQ)), 32'd1);
    chk("req_only_acked", 32'(WritebackREQ & ~WritebackACK), 32'd0);
    if (async_rst_n && RegWriteACK && RegWriteREQ && clk_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_dest", 32'(RegWriteDest), 32'(e.dest));
        chk("out_data", 32'(RegWriteData), 32'(e.data));
        chk("out_src", 32'(RegWriteSrc), 32'(e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < PC; i++) begin
      WritebackDestReg[i*4 +: 4] = dest_tab[i];
      WritebackDataIn[i*DW +: DW] = data_tab[i];
    end
    async_rst_n  = 1'b0;
    clk_en       = 1'b1;
    WritebackACK = 4'b0100;
    RegWriteREQ  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ack", 32'(RegWriteACK), 32'd0);
    chk("rst_dest", 32'(RegWriteDest), 32'd0);
    chk("rst_data", 32'(RegWriteData), 32'd0);
    chk("rst_src", 32'(RegWriteSrc), 32'd0);
    async_rst_n = 1'b1;

    // Single transfer from channel 2, then drain.
    step(4'b0100, 4'b0100);
    chk("t1_valid", 32'(RegWriteACK), 32'd1);
    step(4'b0000, 4'b0000);

    // Fresh reset, then all channels contend: strict 0,1,2,3 rotation.
    async_rst_n = 1'b0;
    #1;
    async_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step(4'b1111, 4'(1 << (k % 4)));
    step(4'b0000, 4'b0000);

    // Back-pressure: full register, ready low for 5 cycles, channel 1 waiting.
    RegWriteREQ = 1'b0;
    step(4'b0001, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      step(4'b0010, 4'b0000);
      chk("bp_valid", 32'(RegWriteACK), 32'd1);
      chk("bp_data", 32'(RegWriteData), 32'h1234);
      chk("bp_src", 32'(RegWriteSrc), 32'd0);
    end
    RegWriteREQ = 1'b1;
    step(4'b0010, 4'b0010);
    step(4'b0000, 4'b0000);

    // clk_en low freezes drain, grant and pointer (pointer sits at 3).
    RegWriteREQ = 1'b0;
    step(4'b0100, 4'b0100);
    clk_en      = 1'b0;
    RegWriteREQ = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(4'b1001, 4'b0000);
      chk("ce_valid", 32'(RegWriteACK), 32'd1);
      chk("ce_data", 32'(RegWriteData), 32'hBEEF);
    end
    clk_en = 1'b1;
    step(4'b1001, 4'b1000);
    step(4'b0000, 4'b0000);

    // Async reset between edges discards the held entry and re-centres the pointer.
    RegWriteREQ = 1'b0;
    step(4'b0010, 4'b0010);
    #1;
    async_rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(RegWriteACK), 32'd0);
    chk("arst_dest", 32'(RegWriteDest), 32'd0);
    chk("arst_data", 32'(RegWriteData), 32'd0);
    exp_q.delete();
    #1;
    async_rst_n = 1'b1;
    RegWriteREQ = 1'b1;
    step(4'b1001, 4'b0001);
    step(4'b1000, 4'b1000);
    step(4'b0000, 4'b0000);

    // Plain drain leaves the stale payload behind.
    chk("stale_valid", 32'(RegWriteACK), 32'd0);
    chk("stale_dest", 32'(RegWriteDest), 32'd14);
    chk("stale_data", 32'(RegWriteData), 32'h0F0F);
    chk("stale_src", 32'(RegWriteSrc), 32'd3);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
